// File: rtl/pyrite_bpi_pkg.sv
// Shared types and helpers for the Pyrite BPI flash sequencer.
// Holds the FSM state enum, the timing counter width and the timing clamp.
package pyrite_bpi_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACCESS,
        HOLD,
        RESP
    } state_t;

    // Timing parameters of 0 behave as 1; values above 255 saturate.
    function automatic logic [CNT_W-1:0] clamp_t(input int t);
        if (t < 1) begin
            return 8'd1;
        end else if (t > 255) begin
            return 8'd255;
        end else begin
            return CNT_W'(t);
        end
    endfunction

endpackage

// File: rtl/pyrite_bpi_rr_arb.sv
// Two-port request arbiter with a one-hot grant.
// PYRITE_BPI_SEQ_RR_EN: round-robin (clk, rst, adv present); else port 0 wins.
// Ports: req (request vector), gnt (one-hot grant), adv (grant accepted).
module pyrite_bpi_rr_arb (
`ifdef PYRITE_BPI_SEQ_RR_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
`endif
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef PYRITE_BPI_SEQ_RR_EN
    // ptr = 1 means port 1 is preferred on the next contention.
    logic ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (adv) begin
            ptr <= gnt[0];
        end
    end

    always_comb begin
        if (ptr) begin
            gnt = {req[1], req[0] & ~req[1]};
        end else begin
            gnt = {req[1] & ~req[0], req[0]};
        end
    end
`else
    assign gnt = {req[1] & ~req[0], req[0]};
`endif

endmodule

// File: rtl/pyrite_bpi_flash_seq.sv
// Two-port BPI flash sequencer: arbitrates word reads/writes and times CE/ADV/OE/WE.
// Ports: req_* (two requesters), resp_* (completion), flash_* (registered pins), busy.
// PYRITE_BPI_SEQ_RR_EN selects round-robin arbitration instead of fixed priority.
module pyrite_bpi_flash_seq
    import pyrite_bpi_pkg::*;
#(
    parameter int FLASH_ADDR_W = 16,
    parameter int FLASH_DATA_W = 16,
    parameter int FLASH_RGN_W  = 1,
    parameter int T_SETUP      = 2,
    parameter int T_ACCESS     = 8,
    parameter int T_HOLD       = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [1:0]                             req_valid,
    output logic [1:0]                             req_ready,
    input  logic [1:0]                             req_write,
    input  logic [2*(FLASH_RGN_W+FLASH_ADDR_W)-1:0] req_addr,
    input  logic [2*FLASH_DATA_W-1:0]              req_wdata,
    output logic [1:0]                             resp_valid,
    output logic [FLASH_DATA_W-1:0]                resp_rdata,
    output logic                                   busy,
    input  logic [FLASH_DATA_W-1:0]                flash_dq_i,
    output logic [FLASH_DATA_W-1:0]                flash_dq_o,
    output logic                                   flash_dq_oe,
    output logic [FLASH_ADDR_W-1:0]                flash_addr,
    output logic [FLASH_RGN_W-1:0]                 flash_region,
    output logic                                   flash_region_oe,
    output logic                                   flash_ce_n,
    output logic                                   flash_oe_n,
    output logic                                   flash_we_n,
    output logic                                   flash_adv_n
);

    localparam int AW = FLASH_RGN_W + FLASH_ADDR_W;
    localparam logic [CNT_W-1:0] TSU = clamp_t(T_SETUP);
    localparam logic [CNT_W-1:0] TAC = clamp_t(T_ACCESS);
    localparam logic [CNT_W-1:0] THD = clamp_t(T_HOLD);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              wr_q, wr_n, own_q;
    logic [1:0]        gnt;
    logic              accept, sel, sel_write;
    logic [AW-1:0]     sel_addr;
    logic [FLASH_DATA_W-1:0] sel_wdata;
    logic              ce_d, adv_d, oe_d, we_d, dqoe_d, rgoe_d;
    logic [1:0]        rv_d;

    pyrite_bpi_rr_arb u_arb (
`ifdef PYRITE_BPI_SEQ_RR_EN
        .clk (clk),
        .rst (rst),
        .adv (accept),
`endif
        .req (req_valid),
        .gnt (gnt)
    );

    assign req_ready = (state == IDLE && !rst) ? gnt : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign sel       = gnt[1];
    assign sel_write = sel ? req_write[1] : req_write[0];
    assign sel_addr  = sel ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
    assign sel_wdata = sel ? req_wdata[2*FLASH_DATA_W-1:FLASH_DATA_W]
                           : req_wdata[FLASH_DATA_W-1:0];
    assign wr_n      = accept ? sel_write : wr_q;
    assign busy      = (state != IDLE);

    // Next state plus next pin levels; pins are registered from these.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ce_d    = 1'b1;
        adv_d   = 1'b1;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        dqoe_d  = 1'b0;
        rgoe_d  = 1'b0;
        rv_d    = 2'b00;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = ADDR;
                    cnt_n   = TSU - 1'b1;
                end
            end
            ADDR: begin
                if (cnt == '0) begin
                    state_n = ACCESS;
                    cnt_n   = TAC - 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_n = HOLD;
                    cnt_n   = THD - 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_n = RESP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        unique case (state_n)
            ADDR: begin
                ce_d   = 1'b0;
                adv_d  = 1'b0;
                rgoe_d = 1'b1;
                dqoe_d = wr_n;
            end
            ACCESS: begin
                ce_d   = 1'b0;
                rgoe_d = 1'b1;
                oe_d   = wr_n;
                we_d   = !wr_n;
                dqoe_d = wr_n;
            end
            HOLD: begin
                ce_d   = 1'b0;
                rgoe_d = 1'b1;
                dqoe_d = wr_n;
            end
            RESP: begin
                rv_d = own_q ? 2'b10 : 2'b01;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            wr_q            <= 1'b0;
            own_q           <= 1'b0;
            flash_ce_n      <= 1'b1;
            flash_adv_n     <= 1'b1;
            flash_oe_n      <= 1'b1;
            flash_we_n      <= 1'b1;
            flash_dq_oe     <= 1'b0;
            flash_region_oe <= 1'b0;
            flash_addr      <= '0;
            flash_region    <= '0;
            flash_dq_o      <= '0;
            resp_rdata      <= '0;
            resp_valid      <= 2'b00;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            flash_ce_n      <= ce_d;
            flash_adv_n     <= adv_d;
            flash_oe_n      <= oe_d;
            flash_we_n      <= we_d;
            flash_dq_oe     <= dqoe_d;
            flash_region_oe <= rgoe_d;
            resp_valid      <= rv_d;
            if (accept) begin
                wr_q  <= sel_write;
                own_q <= sel;
                {flash_region, flash_addr} <= sel_addr;
                if (sel_write) begin
                    flash_dq_o <= sel_wdata;
                end
            end
            // Read data is taken on the edge closing the last ACCESS cycle.
            if (state == ACCESS && cnt == '0 && !wr_q) begin
                resp_rdata <= flash_dq_i;
            end
        end
    end

endmodule

// File: tb/tb_pyrite_bpi_flash_seq.sv
// Directed bench for pyrite_bpi_flash_seq.
// Default timing DUT plus a 0/1/0 timing DUT.
module tb_pyrite_bpi_flash_seq;

  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]      req_valid, req_ready;
  logic [1:0]      req_write, resp_valid;
  logic [2*AW-1:0] req_addr;
  logic [31:0]     req_wdata;
  logic [15:0]     resp_rdata, dq_i, dq_o, faddr;
  logic            busy, dq_oe, freg, freg_oe;
  logic            ce_n, oe_n, we_n, adv_n;

  logic [1:0]      req_valid2, req_ready2;
  logic [1:0]      req_write2, resp_valid2;
  logic [2*AW-1:0] req_addr2;
  logic [31:0]     req_wdata2;
  logic [15:0]     resp_rdata2, dq_i2, dq_o2, faddr2;
  logic            busy2, dq_oe2, freg2, freg_oe2;
  logic            ce_n2, oe_n2, we_n2, adv_n2;

  assign dq_i  = (!ce_n && !oe_n) ? 16'hBEEF : 16'hDEAD;
  assign dq_i2 = (!ce_n2 && !oe_n2) ? 16'h1234 : 16'hDEAD;

  pyrite_bpi_flash_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .busy(busy),
    .flash_dq_i(dq_i), .flash_dq_o(dq_o),
    .flash_dq_oe(dq_oe),
    .flash_addr(faddr), .flash_region(freg),
    .flash_region_oe(freg_oe),
    .flash_ce_n(ce_n), .flash_oe_n(oe_n),
    .flash_we_n(we_n), .flash_adv_n(adv_n)
  );

  pyrite_bpi_flash_seq #(
    .T_SETUP(0), .T_ACCESS(1), .T_HOLD(0)
  ) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write2), .req_addr(req_addr2),
    .req_wdata(req_wdata2),
    .resp_valid(resp_valid2), .resp_rdata(resp_rdata2),
    .busy(busy2),
    .flash_dq_i(dq_i2), .flash_dq_o(dq_o2),
    .flash_dq_oe(dq_oe2),
    .flash_addr(faddr2), .flash_region(freg2),
    .flash_region_oe(freg_oe2),
    .flash_ce_n(ce_n2), .flash_oe_n(oe_n2),
    .flash_we_n(we_n2), .flash_adv_n(adv_n2)
  );

  int checks = 0;
  int errors = 0;

  int          lat, n_oe, n_we, n_adv, n_dqoe;
  logic [1:0]  rmask;
  logic [15:0] rdata;
  logic        addr_ok, dq_ok, acc_ok;

  task automatic chk(input string tag, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic xact(
    input bit w2, input int p, input logic wr,
    input logic [15:0] a, input logic rg,
    input logic [15:0] d
  );
    logic rdy, c_ce, c_oe, c_we, c_adv;
    logic c_dqoe, c_reg, c_rgoe;
    logic [15:0] c_addr, c_dqo, c_rd;
    logic [1:0]  c_rv;
    lat = 0; n_oe = 0; n_we = 0;
    n_adv = 0; n_dqoe = 0;
    rmask = 2'b00; rdata = 16'h0;
    addr_ok = 1'b1; dq_ok = 1'b1;
    acc_ok = 1'b0;
    if (w2) begin
      req_write2[p] = wr;
      req_addr2[p*AW +: AW] = {rg, a};
      req_wdata2[p*16 +: 16] = d;
      req_valid2[p] = 1'b1;
    end else begin
      req_write[p] = wr;
      req_addr[p*AW +: AW] = {rg, a};
      req_wdata[p*16 +: 16] = d;
      req_valid[p] = 1'b1;
    end
    for (int i = 0; i < 50; i++) begin
      #1;
      rdy = w2 ? req_ready2[p] : req_ready[p];
      if (rdy) begin
        acc_ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!acc_ok) begin
      req_valid = 2'b00;
      req_valid2 = 2'b00;
      return;
    end
    @(posedge clk);
    #1;
    if (w2) req_valid2[p] = 1'b0;
    else    req_valid[p] = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      c_ce   = w2 ? ce_n2    : ce_n;
      c_oe   = w2 ? oe_n2    : oe_n;
      c_we   = w2 ? we_n2    : we_n;
      c_adv  = w2 ? adv_n2   : adv_n;
      c_dqoe = w2 ? dq_oe2   : dq_oe;
      c_reg  = w2 ? freg2    : freg;
      c_rgoe = w2 ? freg_oe2 : freg_oe;
      c_addr = w2 ? faddr2   : faddr;
      c_dqo  = w2 ? dq_o2    : dq_o;
      c_rd   = w2 ? resp_rdata2 : resp_rdata;
      c_rv   = w2 ? resp_valid2 : resp_valid;
      if (!c_oe) n_oe++;
      if (!c_we) n_we++;
      if (!c_adv) n_adv++;
      if (c_dqoe) n_dqoe++;
      if (!c_ce && ({c_reg, c_addr} !== {rg, a}
          || !c_rgoe))
        addr_ok = 1'b0;
      if (c_dqoe && c_dqo !== d) dq_ok = 1'b0;
      if (|c_rv) begin
        rmask = c_rv;
        lat = i;
        rdata = c_rd;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] g;
  logic [1:0] exp_g;
  logic       got, saw;

  initial begin
    rst = 1'b1;
    req_valid = 2'b00; req_write = 2'b00;
    req_addr = '0; req_wdata = '0;
    req_valid2 = 2'b00; req_write2 = 2'b00;
    req_addr2 = '0; req_wdata2 = '0;
    repeat (3) @(posedge clk);
    req_valid = 2'b11;
    @(negedge clk);
    chk("rst_strobes",
        {ce_n, oe_n, we_n, adv_n} === 4'b1111);
    chk("rst_oe", {dq_oe, freg_oe} === 2'b00);
    chk("rst_pins",
        {freg, faddr, dq_o} === 33'h0);
    chk("rst_ready", req_ready === 2'b00);
    chk("rst_resp",
        {resp_valid, resp_rdata, busy} === 19'h0);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    xact(0, 0, 1'b0, 16'h0123, 1'b0, 16'h0000);
    chk("rd_latency", lat === 13);
    chk("rd_owner", rmask === 2'b01);
    chk("rd_data", rdata === 16'hBEEF);
    chk("rd_oe_cycles", n_oe === 8);
    chk("rd_adv_cycles", n_adv === 2);
    chk("rd_no_we_dq",
        {n_we[7:0], n_dqoe[7:0]} === 16'h0);
    chk("rd_addr", addr_ok === 1'b1);

    xact(0, 1, 1'b1, 16'h0040, 1'b1, 16'h5A5A);
    chk("wr_latency", lat === 13);
    chk("wr_owner", rmask === 2'b10);
    chk("wr_we_cycles", n_we === 8);
    chk("wr_oe_cycles", n_oe === 0);
    chk("wr_dqoe_cycles", n_dqoe === 12);
    chk("wr_dq", dq_ok === 1'b1);
    chk("wr_addr_rgn", addr_ok === 1'b1);
    chk("wr_rdata_kept", rdata === 16'hBEEF);

    req_write = 2'b00;
    req_addr = {1'b0, 16'h0200, 1'b0, 16'h0100};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      g = 2'b00;
      for (int i = 0; i < 50; i++) begin
        #1;
        if (|req_ready) begin
          g = req_ready;
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
`ifdef PYRITE_BPI_SEQ_RR_EN
      exp_g = k[0] ? 2'b10 : 2'b01;
`else
      exp_g = 2'b01;
`endif
      chk("arb_grant", g === exp_g);
      if (!got) break;
      @(posedge clk);
      saw = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (|resp_valid) begin
          saw = 1'b1;
          break;
        end
      end
      chk("arb_resp", resp_valid === exp_g);
      if (!saw) break;
    end
    req_valid = 2'b00;

    @(negedge clk);
    req_write[0] = 1'b0;
    req_addr[AW-1:0] = {1'b0, 16'h0077};
    req_valid[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (req_ready[0]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rstmid_accept", got === 1'b1);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (5) @(negedge clk);
    chk("rstmid_in_access",
        {oe_n, adv_n, ce_n} === 3'b010);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_strobes",
        {ce_n, oe_n, we_n, adv_n} === 4'b1111);
    chk("rstmid_oe", {dq_oe, freg_oe} === 2'b00);
    chk("rstmid_resp",
        {resp_valid, busy} === 3'b000);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (|resp_valid) saw = 1'b1;
    end
    chk("rstmid_no_resp", saw === 1'b0);
    xact(0, 1, 1'b0, 16'h0555, 1'b0, 16'h0000);
    chk("after_rst_latency", lat === 13);
    chk("after_rst_owner", rmask === 2'b10);
    chk("after_rst_data", rdata === 16'hBEEF);

    xact(1, 0, 1'b0, 16'h0010, 1'b0, 16'h0000);
    chk("clamp_latency", lat === 4);
    chk("clamp_oe_adv",
        {n_oe[7:0], n_adv[7:0]} === 16'h0101);
    chk("clamp_data", rdata === 16'h1234);
    chk("clamp_owner", rmask === 2'b01);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/pyrite_bpi_flash_seq.md
# pyrite_bpi_flash_seq

Two-port BPI flash access sequencer for Pyrite flashing support. It arbitrates word-level read and write requests from two requesters, e.g. the VPD register path and an on-chip loader. It converts each granted request into a timed CE#/ADV#/OE#/WE# pin sequence with programmable setup, access and hold cycles. It sits between the requesters and the BPI flash I/O pins, replacing software bit-banging of the control lines.

## Interface
Parameters:
- FLASH_ADDR_W, 16, flash address pin width
- FLASH_DATA_W, 16, flash DQ width
- FLASH_RGN_W, 1, region (upper address) pin width
- T_SETUP, 2, cycles in ADDR state (1..255; 0 treated as 1)
- T_ACCESS, 8, cycles of OE#/WE# low (1..255; 0 treated as 1)
- T_HOLD, 2, cycles of strobes high with addr/data held (1..255; 0 treated as 1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  2  request valid, one bit per port
- req_ready  out  2  request accepted when valid&&ready
- req_write  in  2  1 = write, 0 = read
- req_addr  in  2*(FLASH_RGN_W+FLASH_ADDR_W)  per-port {region, addr}, port 0 in LSBs
- req_wdata  in  2*FLASH_DATA_W  per-port write data
- resp_valid  out  2  one-cycle completion pulse to the owning port
- resp_rdata  out  FLASH_DATA_W  read data, valid with resp_valid (shared)
- busy  out  1  transaction in progress
- flash_dq_i  in  FLASH_DATA_W  flash data in
- flash_dq_o  out  FLASH_DATA_W  flash data out
- flash_dq_oe  out  1  DQ drive enable
- flash_addr  out  FLASH_ADDR_W  address pins
- flash_region  out  FLASH_RGN_W  region pins
- flash_region_oe  out  1  region drive enable
- flash_ce_n, flash_oe_n, flash_we_n, flash_adv_n  out  1 each  active-low strobes

## Operation
- States: IDLE, ADDR, ACCESS, HOLD, RESP. An 8-bit down-counter times ADDR, ACCESS and HOLD.
- IDLE: req_ready is high only for the granted port, and only if that port's req_valid is high. On accept: latch write, addr and wdata; record the owner; go to ADDR.
- ADDR (T_SETUP cycles): ce_n=0, adv_n=0, region_oe=1, addr/region driven. For writes, dq_oe=1 and dq_o=wdata.
- ACCESS (T_ACCESS cycles): adv_n=1. Reads drive oe_n=0. Writes drive we_n=0 and dq_oe=1. For reads, resp_rdata captures flash_dq_i at the clock edge that ends the last ACCESS cycle.
- HOLD (T_HOLD cycles): oe_n=we_n=1 and ce_n=0. Addr, region and dq_o are unchanged, and dq_oe stays as in ACCESS.
- RESP (1 cycle): ce_n=1, dq_oe=0, region_oe=0, resp_valid[owner]=1. Writes leave resp_rdata at its previous value. Go to IDLE.
- busy=1 in every state except IDLE.
- Arbitration happens only in IDLE and is combinational on req_valid. A port must hold valid and payload stable until accepted.
- Reset values: strobes all 1; dq_oe=0, region_oe=0; flash_addr, flash_region, dq_o, resp_rdata=0; req_ready=0, resp_valid=0, busy=0; round-robin pointer = port 0 preferred.
- Reset mid-transaction: all strobes high and drive enables low at the next edge, with no resp_valid. Requesters must reissue.

## Timing
- Accept edge to resp_valid: T_SETUP+T_ACCESS+T_HOLD+1 cycles. With defaults, resp_valid is asserted 13 cycles after the accept edge.
- Earliest next accept is the cycle after RESP. Back-to-back throughput is T_SETUP+T_ACCESS+T_HOLD+2 cycles per word.
- All flash outputs are registered, with no combinational path from req_* to pins.
- Both ports valid in the same IDLE cycle: resolved by the arbitration policy under Configuration. The loser keeps req_ready=0.

## Configuration
- PYRITE_BPI_SEQ_RR_EN defined: round-robin arbitration. The pointer moves to the non-granted port after each accept, so with both ports continuously valid, grants alternate 0,1,0,1.
- PYRITE_BPI_SEQ_RR_EN undefined: fixed priority, port 0 always wins, and the pointer logic is absent.

## Structure
- Package pyrite_bpi_pkg holds:
  - state enum (IDLE, ADDR, ACCESS, HOLD, RESP)
  - counter width constant (8)
  - clamp function max(T,1) used for the timing parameters
- Sub-module pyrite_bpi_rr_arb is a 2-port arbiter: request vector in, one-hot grant out, advanced on accept. It contains both policies, selected by the macro.

## Test plan
- Port 0 reads 0x0123 with flash model returning 0xBEEF (defaults) -> resp_valid[0] 13 cycles after accept, resp_rdata=0xBEEF, oe_n low exactly 8 cycles, adv_n low exactly 2.
- Port 1 writes 0x5A5A to 0x0040 region 1 -> we_n low 8 cycles, dq_oe high ADDR through HOLD, dq_o=0x5A5A, flash_region=1, resp_valid[1] only.
- Both ports valid continuously for 4 transactions -> RR_EN grants 0,1,0,1; without macro 0,0,0,0.
- rst asserted in 3rd ACCESS cycle -> next edge all strobes 1, dq_oe=0, no resp_valid; next request completes normally.
- T_SETUP=0, T_ACCESS=1, T_HOLD=0 -> treated as 1/1/1, resp_valid 4 cycles after accept.
